// File: rtl/alu_cmd_ctrl_if.sv
// Byte-command / ALU / transmitter signal bundle for alu_cmd_ctrl.
// slave: the controller side. master: the environment (receiver, ALU, transmitter).
interface alu_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        frm_err;
  logic        rx_drop;

  modport slave (
    input  rx_data, rx_valid, alu_out, tx_ready,
    output alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, frm_err, rx_drop
  );

  modport master (
    output rx_data, rx_valid, alu_out, tx_ready,
    input  alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, frm_err, rx_drop
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Frame-driven ALU command controller.
// Frame: CMD_BYTE, operand A, operand B, function byte (upper nibble must be 0).
// After ALU_LAT cycles of alu_en the 16-bit result is sent low byte first.
// Optional: define ALU_CMD_TIMEOUT_EN to abort a frame after TMO_CYC idle cycles
// in the operand/function collection states.
module alu_cmd_ctrl #(
  parameter logic [7:0]  CMD_BYTE = 8'hCC,
  parameter int unsigned ALU_LAT  = 2,
  parameter int unsigned TMO_CYC  = 255
) (
  input logic          clk,
  input logic          rst_n,
  alu_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StGetA, StGetB, StGetFun, StAluRun, StSendLo, StSendHi
  } state_e;

  localparam int unsigned LatW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(ALU_LAT - 1);

  state_e          state_q, state_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [3:0]      alu_fun_q, alu_fun_d;
  logic [15:0]     result_q, result_d;
  logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
  logic            frm_err_q, frm_err_d;
  logic            rx_drop_q, rx_drop_d;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int unsigned TmoW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYC - 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state, operand capture and pulse generation.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    result_d  = result_q;
    lat_cnt_d = '0;
    frm_err_d = 1'b0;
    rx_drop_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid && (bus.rx_data == CMD_BYTE)) state_d = StGetA;
      end
      StGetA: begin
        if (bus.rx_valid) begin
          alu_a_d = bus.rx_data;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (bus.rx_valid) begin
          alu_b_d = bus.rx_data;
          state_d = StGetFun;
        end
      end
      StGetFun: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[7:4] == 4'h0) begin
            alu_fun_d = bus.rx_data[3:0];
            state_d   = StAluRun;
          end else begin
            frm_err_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StAluRun: begin
        rx_drop_d = bus.rx_valid;
        if (lat_cnt_q == LatLast) begin
          result_d = bus.alu_out;
          state_d  = StSendLo;
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
        end
      end
      StSendLo: begin
        rx_drop_d = bus.rx_valid;
        if (bus.tx_ready) state_d = StSendHi;
      end
      StSendHi: begin
        rx_drop_d = bus.rx_valid;
        if (bus.tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef ALU_CMD_TIMEOUT_EN
    // Idle-cycle counter; any received byte or leaving the collect states clears it.
    tmo_cnt_d = '0;
    if (!bus.rx_valid && (state_q inside {StGetA, StGetB, StGetFun})) begin
      if (tmo_cnt_q == TmoLast) begin
        frm_err_d = 1'b1;
        state_d   = StIdle;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      end
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      result_q  <= '0;
      lat_cnt_q <= '0;
      frm_err_q <= 1'b0;
      rx_drop_q <= 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      result_q  <= result_d;
      lat_cnt_q <= lat_cnt_d;
      frm_err_q <= frm_err_d;
      rx_drop_q <= rx_drop_d;
`ifdef ALU_CMD_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  // Outputs decode from state so reset clears them without waiting for a clock.
  always_comb begin
    bus.alu_a    = alu_a_q;
    bus.alu_b    = alu_b_q;
    bus.alu_fun  = alu_fun_q;
    bus.frm_err  = frm_err_q;
    bus.rx_drop  = rx_drop_q;
    bus.alu_en   = (state_q == StAluRun);
    bus.tx_valid = (state_q == StSendLo) || (state_q == StSendHi);
    bus.tx_data  = 8'h00;
    if (state_q == StSendLo) bus.tx_data = result_q[7:0];
    if (state_q == StSendHi) bus.tx_data = result_q[15:8];
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl; the ALU result is driven as a hand-computed constant.
module tb_alu_cmd_ctrl;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  alu_cmd_ctrl_if bus ();

  alu_cmd_ctrl #(
    .CMD_BYTE(8'hCC),
    .ALU_LAT (2),
    .TMO_CYC (255)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // One-cycle rx_valid pulse; returns 1 time unit after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.tx_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Collects both result bytes with tx_ready held high.
  task automatic recv_two(output logic [7:0] lo, output logic [7:0] hi, output int cyc);
    wait_valid(cyc);
    lo = bus.tx_data;
    @(posedge clk); #1;
    hi = (bus.tx_valid === 1'b1) ? bus.tx_data : 8'hxx;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++; if (bus.alu_a !== 8'h00) begin bad++; $display("FAIL reset_alu_a got=%h exp=00", bus.alu_a); end
    total++; if (bus.alu_b !== 8'h00) begin bad++; $display("FAIL reset_alu_b got=%h exp=00", bus.alu_b); end
    total++; if (bus.alu_fun !== 4'h0) begin bad++; $display("FAIL reset_alu_fun got=%h exp=0", bus.alu_fun); end
    total++; if ({bus.alu_en, bus.tx_valid, bus.frm_err, bus.rx_drop} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000",
                      {bus.alu_en, bus.tx_valid, bus.frm_err, bus.rx_drop});
    end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add;
    logic [7:0] lo, hi;
    int cyc;
    bus.alu_out  = 16'h0008;
    bus.tx_ready = 1'b1;
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    total++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== {8'h05, 8'h03, 4'h0}) begin
      bad++; $display("FAIL add_operands got=%h exp=05030", {bus.alu_a, bus.alu_b, bus.alu_fun});
    end
    total++; if (bus.alu_en !== 1'b1) begin bad++; $display("FAIL add_alu_en got=%b exp=1", bus.alu_en); end
    recv_two(lo, hi, cyc);
    total++; if (cyc != 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", cyc); end
    total++; if ({lo, hi} !== 16'h0800) begin bad++; $display("FAIL add_tx got=%h exp=0800", {lo, hi}); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL add_tx_end got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_mul;
    logic [7:0] lo, hi;
    int cyc;
    bus.alu_out = 16'hFE01;
    send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    recv_two(lo, hi, cyc);
    total++; if (cyc != 2) begin bad++; $display("FAIL mul_latency got=%0d exp=2", cyc); end
    total++; if ({lo, hi} !== 16'h01FE) begin bad++; $display("FAIL mul_tx got=%h exp=01FE", {lo, hi}); end
  endtask

  task automatic test_ignore;
    logic [7:0] lo, hi;
    int cyc;
    bus.alu_out = 16'h1234;
    send_byte(8'hAB);
    total++; if ({bus.frm_err, bus.rx_drop} !== 2'b00) begin
      bad++; $display("FAIL ignore_silent got=%b exp=00", {bus.frm_err, bus.rx_drop});
    end
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h02); send_byte(8'h0D);
    total++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== {8'h07, 8'h02, 4'hD}) begin
      bad++; $display("FAIL ignore_operands got=%h exp=0702D", {bus.alu_a, bus.alu_b, bus.alu_fun});
    end
    recv_two(lo, hi, cyc);
    total++; if ({lo, hi} !== 16'h3412) begin bad++; $display("FAIL ignore_tx got=%h exp=3412", {lo, hi}); end
  endtask

  task automatic test_frm_err;
    bit saw_tx = 1'b0;
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h1F);
    total++; if (bus.frm_err !== 1'b1) begin bad++; $display("FAIL frm_err_pulse got=%b exp=1", bus.frm_err); end
    total++; if (bus.alu_fun !== 4'hD) begin bad++; $display("FAIL frm_err_fun got=%h exp=D", bus.alu_fun); end
    @(posedge clk); #1;
    total++; if (bus.frm_err !== 1'b0) begin bad++; $display("FAIL frm_err_single got=%b exp=0", bus.frm_err); end
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_valid !== 1'b0 || bus.alu_en !== 1'b0) saw_tx = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (saw_tx !== 1'b0) begin bad++; $display("FAIL frm_err_no_tx got=%b exp=0", saw_tx); end
  endtask

  // CMD_BYTE as operand data, frame started straight after an aborted one.
  task automatic test_back_to_back;
    logic [7:0] lo, hi;
    int cyc;
    bus.alu_out = 16'h0198;
    send_byte(8'hCC); send_byte(8'hCC); send_byte(8'hCC); send_byte(8'h01);
    total++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== {8'hCC, 8'hCC, 4'h1}) begin
      bad++; $display("FAIL b2b_operands got=%h exp=CCCC1", {bus.alu_a, bus.alu_b, bus.alu_fun});
    end
    recv_two(lo, hi, cyc);
    total++; if ({lo, hi} !== 16'h9801) begin bad++; $display("FAIL b2b_tx got=%h exp=9801", {lo, hi}); end
  endtask

  task automatic test_stall;
    int cyc;
    int unstable = 0;
    int drops = 0;
    bus.alu_out  = 16'hBEEF;
    bus.tx_ready = 1'b0;
    send_byte(8'hCC); send_byte(8'h11); send_byte(8'h22); send_byte(8'h03);
    wait_valid(cyc);
    total++; if (bus.tx_data !== 8'hEF) begin bad++; $display("FAIL stall_lo got=%h exp=EF", bus.tx_data); end
    for (int i = 0; i < 10; i++) begin
      bus.rx_valid = (i == 2);
      bus.rx_data  = 8'h55;
      @(posedge clk); #1;
      if (bus.rx_drop === 1'b1) drops++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hEF) unstable++;
    end
    bus.rx_valid = 1'b0;
    total++; if (unstable != 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
    total++; if (drops != 1) begin bad++; $display("FAIL stall_rx_drop got=%0d exp=1", drops); end
    total++; if (bus.alu_a !== 8'h11) begin bad++; $display("FAIL stall_alu_a got=%h exp=11", bus.alu_a); end
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hBE}) begin
      bad++; $display("FAIL stall_hi got=%h exp=1BE", {bus.tx_valid, bus.tx_data});
    end
    @(posedge clk); #1;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL stall_end got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_reset_abort;
    logic [7:0] lo, hi;
    int cyc;
    bus.alu_out  = 16'h7766;
    bus.tx_ready = 1'b0;
    send_byte(8'hCC); send_byte(8'h09); send_byte(8'h08); send_byte(8'h04);
    wait_valid(cyc);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    total++; if (bus.tx_data !== 8'h77) begin bad++; $display("FAIL abort_in_hi got=%h exp=77", bus.tx_data); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.tx_valid, bus.tx_data, bus.alu_a} !== 17'h0) begin
      bad++; $display("FAIL abort_immediate got=%h exp=0", {bus.tx_valid, bus.tx_data, bus.alu_a});
    end
    @(posedge clk); #1;
    // Release mid-cycle and present CMD_BYTE for the very first edge.
    rst_n        = 1'b1;
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hCC;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL abort_no_tx got=%b exp=0", bus.tx_valid); end
    bus.alu_out = 16'h00AA;
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h04);
    total++; if ({bus.alu_a, bus.alu_b} !== 16'h0506) begin
      bad++; $display("FAIL first_edge_cmd got=%h exp=0506", {bus.alu_a, bus.alu_b});
    end
    recv_two(lo, hi, cyc);
    total++; if ({lo, hi} !== 16'hAA00) begin bad++; $display("FAIL first_edge_tx got=%h exp=AA00", {lo, hi}); end
  endtask

  task automatic test_timeout;
    int k = 0;
    bus.alu_out = 16'h0015;
    send_byte(8'hCC); send_byte(8'h01);
    while (bus.frm_err !== 1'b1 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
`ifdef ALU_CMD_TIMEOUT_EN
    total++; if (k != 255) begin bad++; $display("FAIL timeout_cycles got=%0d exp=255", k); end
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h01);
    total++; if ({bus.alu_a, bus.alu_b} !== 16'h0A0B) begin
      bad++; $display("FAIL timeout_idle got=%h exp=0A0B", {bus.alu_a, bus.alu_b});
    end
`else
    total++; if (k != 300) begin bad++; $display("FAIL no_timeout got=%0d exp=300", k); end
    send_byte(8'h0B); send_byte(8'h01);
    total++; if ({bus.alu_a, bus.alu_b} !== 16'h010B) begin
      bad++; $display("FAIL no_timeout_resume got=%h exp=010B", {bus.alu_a, bus.alu_b});
    end
`endif
    begin
      logic [7:0] lo, hi;
      int cyc;
      recv_two(lo, hi, cyc);
      total++; if ({lo, hi} !== 16'h1500) begin bad++; $display("FAIL timeout_tx got=%h exp=1500", {lo, hi}); end
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.alu_out  = 16'h0000;
    bus.tx_ready = 1'b1;
    test_reset();
    test_basic_add();
    test_mul();
    test_ignore();
    test_frm_err();
    test_back_to_back();
    test_stall();
    test_reset_abort();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameter: CMD_BYTE, default 8'hCC, frame start byte.
REQ-002 Parameter: ALU_LAT, default 2, cycles from alu_en assertion to alu_out sample.
REQ-003 Parameter: TMO_CYC, default 255, inter-byte timeout in cycles.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 rx_data  in  8  received byte.
REQ-008 rx_valid  in  1  one-cycle pulse, rx_data valid.
REQ-009 alu_a, alu_b  out  8 each  ALU operands.
REQ-010 alu_fun  out  4  ALU function code.
REQ-011 alu_en  out  1  high while an operation is in flight.
REQ-012 alu_out  in  16  registered ALU result.
REQ-013 tx_data  out  8  result byte to transmitter.
REQ-014 tx_valid  out  1  tx_data valid.
REQ-015 tx_ready  in  1  transmitter accepts byte when tx_valid and tx_ready both high.
REQ-016 frm_err  out  1  one-cycle pulse on a rejected frame.
REQ-017 rx_drop  out  1  one-cycle pulse on a byte received while busy.

Function
REQ-018 FSM states: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, SEND_LO, SEND_HI.
REQ-019 IDLE: rx_valid with rx_data==CMD_BYTE -> GET_A; any other byte ignored, no pulse.
REQ-020 GET_A/GET_B: rx_valid latches byte into alu_a/alu_b, advances to next state.
REQ-021 GET_FUN: rx_valid with rx_data[7:4]==0 latches rx_data[3:0] into alu_fun -> ALU_RUN; otherwise frm_err pulse -> IDLE, alu_fun unchanged.
REQ-022 ALU_RUN: alu_en high for exactly ALU_LAT cycles; on the last cycle alu_out is captured into a 16-bit result register -> SEND_LO.
REQ-023 alu_a, alu_b, alu_fun SHALL remain stable from capture until the next frame overwrites them.
REQ-024 SEND_LO: tx_valid high, tx_data = result[7:0]; on tx_valid&&tx_ready -> SEND_HI.
REQ-025 SEND_HI: tx_valid high, tx_data = result[15:8]; on handshake -> IDLE, tx_valid low next cycle.
REQ-026 tx_valid and tx_data SHALL not change while tx_valid high and tx_ready low.
REQ-027 rx_valid in ALU_RUN, SEND_LO or SEND_HI: byte discarded, rx_drop pulses next cycle.
REQ-028 Minimum frame-to-first-tx latency: tx_valid rises ALU_LAT+1 cycles after the FUN-byte rx_valid cycle.
REQ-029 A CMD_BYTE value received in GET_A/GET_B is treated as operand data, not a restart.

Reset
REQ-030 rst_n low SHALL force immediately: state IDLE; alu_a, alu_b, alu_fun, result, tx_data = 0; alu_en, tx_valid, frm_err, rx_drop = 0.
REQ-031 Reset mid-frame or mid-send SHALL abort; no partial byte transmitted after release.
REQ-032 First rising clk after rst_n deassertion SHALL be able to accept a CMD_BYTE.

Configuration
REQ-033 Macro ALU_CMD_TIMEOUT_EN defined: a counter reloads on every rx_valid; in GET_A/GET_B/GET_FUN, TMO_CYC cycles without rx_valid -> frm_err pulse, state IDLE.
REQ-034 Macro undefined: no timeout counter; GET states wait indefinitely.

Verification
REQ-035 Bytes CC,05,03,00, tx_ready=1 -> alu_a=05, alu_b=03, alu_fun=0; tx bytes 08 then 00; alu_out driven 0x0008.
REQ-036 Bytes CC,FF,FF,02 with alu_out=0xFE01 -> tx bytes 01 then FE; tx_valid rises 3 cycles after FUN byte.
REQ-037 Bytes AB,CC,07,02,0D -> AB ignored silently; frame completes, alu_fun=D.
REQ-038 Bytes CC,01,02,1F -> frm_err single pulse, no tx_valid, return to IDLE.
REQ-039 tx_ready low 10 cycles during SEND_LO, extra rx byte injected -> tx_data/tx_valid stable, rx_drop pulses once, then 2 bytes sent.
REQ-040 With ALU_CMD_TIMEOUT_EN: CC,01 then 255 idle cycles -> frm_err pulse, IDLE; rst_n low during SEND_HI -> tx_valid 0 immediately.
